sram_bank_arbiter: RTL and testbench
====================================

Name: sram_bank_arbiter

Overview:
- Shares the four-bank SRAM buffer between three requesters: host load (weights/inputs write), array feed (systolic operand read) and activation writeback (result write).
- Sits between the controller-side requesters and the SRAM buffer. Drives the buffer's ren/wen/addr/chip_select/write data and returns read data to the array feed.
- Issues one access per cycle using round-robin arbitration. A requester can lock the arbiter to keep ownership for a burst.

Parameters:
- ADDR_W, 10, word address width per bank
- DATA_W, 64, data word width
- NUM_BANKS, 4, SRAM banks; one-hot chip select width
- DEPTH, 1024, valid words per bank; addr >= DEPTH is out of range

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- h_req, a_req, w_req  in  1 each  request: host write, array read, writeback write
- h_lock, w_lock  in  1 each  hold ownership for a burst (write requesters only)
- h_addr, a_addr, w_addr  in  ADDR_W each  word address
- h_bank, a_bank, w_bank  in  2 each  bank index
- h_wdata, w_wdata  in  DATA_W each  write data
- h_gnt, a_gnt, w_gnt  out  1 each  combinational grant; at most one high per cycle
- a_rvalid  out  1  a_rdata valid
- a_rdata  out  DATA_W  read data muxed from the granted bank
- ren, wen  out  1 each  registered SRAM command
- addr  out  ADDR_W  registered SRAM address
- chip_select  out  NUM_BANKS  registered, one-hot
- write_data  out  DATA_W  registered, broadcast to all banks
- read_data0..3  in  DATA_W each  per-bank SRAM read data
- addr_err  out  1  one-cycle pulse when a granted access is out of range
- wait_h, wait_a, wait_w  out  16 each  per-requester wait counters (optional feature)

Behaviour:
- Reset: all outputs 0; state ARB; round-robin pointer at host; read pipeline cleared; any pending rvalid is dropped.
- Grant is combinational in the request cycle N. A requester holds req and payload until it sees gnt high. It may present a new payload in cycle N+1 (back-to-back allowed).
- SRAM command is registered at the edge ending cycle N and is valid in cycle N+1.
  - Writes: wen=1, ren=0.
  - Reads: ren=1, wen=0.
  - With no grant, ren=wen=0 and chip_select=0.
- Read latency: the buffer returns data in N+2. The arbiter selects read_dataX using the bank registered with the command and asserts a_rvalid plus a_rdata in N+2. A read is fully pipelined: a read every cycle gives a_rvalid every cycle.
- Round-robin: the pointer names the highest-priority requester; order is host -> array -> writeback -> host. After a grant, the pointer moves to the requester after the granted one. With no request, the pointer holds.
- FSM:
  - ARB: round-robin as above. If the grant goes to host with h_lock=1, or to writeback with w_lock=1, go to LOCK with owner recorded.
  - LOCK: only the owner can be granted; others wait. Return to ARB on the first owner grant with lock=0, or any cycle the owner has req=0 and lock=0. In LOCK the pointer is frozen; on exit it moves to the requester after the owner.
  - a_req arriving during LOCK simply waits.
- Range check: a granted access with addr >= DEPTH still gets its gnt so the requester cannot hang. The command is suppressed: ren=wen=0, chip_select=0. addr_err pulses in N+1. A suppressed read produces no a_rvalid.
- One access per cycle, so there are no same-cycle hazards. A write in N followed by a read of the same word in N+1 returns the new data (SRAM write-first); no forwarding is done in the arbiter.

Optional Feature:
- Macro SRAM_ARB_PERF_CNT_EN.
- With it: wait_h/a/w count cycles where the requester's req=1 and gnt=0. The counters saturate at 16'hFFFF and clear on reset.
- Without it: the counter logic is absent and the wait_* ports are tied to 0.

Decomposition:
- Package sram_arb_pkg holds:
  - requester enum: REQ_HOST=0, REQ_ARRAY=1, REQ_WB=2
  - NUM_REQ=3
  - state enum: ARB, LOCK
- Sub-module rr_arbiter3: combinational 3-way round-robin grant from req[2:0] and pointer. The pointer register and FSM stay in the top.

Test Plan:
- Reset high after a request burst -> all outputs 0; first grant with all three requesting goes to host.
- h/a/w request continuously -> grants rotate h,a,w,h,a,w. Host write bank 2, addr 5 -> chip_select=4'b0100, addr=5, wen=1 one cycle after h_gnt.
- Preload bank 1 addr 0..3 = 0xA0..0xA3, then a_req for 4 back-to-back cycles -> a_rvalid for 4 consecutive cycles starting 2 cycles after the first grant, with data 0xA0..0xA3.
- w_lock held for 6 writes while a_req=1 -> a_gnt stays low until the last w_gnt with w_lock=0; a_gnt follows in the next cycle.
- DEPTH=512, h_addr=600 -> h_gnt=1, addr_err pulse, no wen, no chip select; a read to addr 600 produces no a_rvalid.
- Assert n_rst in the cycle after a read grant -> a_rvalid never asserts; with SRAM_ARB_PERF_CNT_EN, wait_a counts 2 for an a_req stalled behind two host grants.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bank arbiter: requester ids, FSM states and
// the round-robin successor helper.
package sram_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        REQ_HOST  = 2'd0,
        REQ_ARRAY = 2'd1,
        REQ_WB    = 2'd2
    } req_id_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic req_id_t next_req(input req_id_t r);
        case (r)
            REQ_HOST:  return REQ_ARRAY;
            REQ_ARRAY: return REQ_WB;
            default:   return REQ_HOST;
        endcase
    endfunction

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester, SRAM and wait-counter signals of the SRAM bank arbiter.
// slave = arbiter side, master = requesters/SRAM side.
interface sram_bank_arbiter_if #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 4
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic              h_req, a_req, w_req;
    logic              h_lock, w_lock;
    logic [ADDR_W-1:0] h_addr, a_addr, w_addr;
    logic [BANK_W-1:0] h_bank, a_bank, w_bank;
    logic [DATA_W-1:0] h_wdata, w_wdata;
    logic              h_gnt, a_gnt, w_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic              ren, wen;
    logic [ADDR_W-1:0] addr;
    logic [NUM_BANKS-1:0] chip_select;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data0, read_data1, read_data2, read_data3;
    logic              addr_err;
    logic [15:0]       wait_h, wait_a, wait_w;

    modport slave (
        input  h_req, a_req, w_req, h_lock, w_lock,
        input  h_addr, a_addr, w_addr, h_bank, a_bank, w_bank,
        input  h_wdata, w_wdata,
        input  read_data0, read_data1, read_data2, read_data3,
        output h_gnt, a_gnt, w_gnt, a_rvalid, a_rdata,
        output ren, wen, addr, chip_select, write_data, addr_err,
        output wait_h, wait_a, wait_w
    );

    modport master (
        output h_req, a_req, w_req, h_lock, w_lock,
        output h_addr, a_addr, w_addr, h_bank, a_bank, w_bank,
        output h_wdata, w_wdata,
        output read_data0, read_data1, read_data2, read_data3,
        input  h_gnt, a_gnt, w_gnt, a_rvalid, a_rdata,
        input  ren, wen, addr, chip_select, write_data, addr_err,
        input  wait_h, wait_a, wait_w
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin grant; ptr names the highest-priority
// requester. Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
module rr_arbiter3
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] pick;

    always_comb begin
        rot = req;
        case (ptr)
            REQ_ARRAY: rot = {req[0], req[2:1]};
            REQ_WB:    rot = {req[1:0], req[2]};
            default:   rot = req;
        endcase
    end

    assign pick = rot & (~rot + 3'd1);

    always_comb begin
        gnt = pick;
        case (ptr)
            REQ_ARRAY: gnt = {pick[1:0], pick[2]};
            REQ_WB:    gnt = {pick[0], pick[2:1]};
            default:   gnt = pick;
        endcase
    end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing a four-bank SRAM between host load, array feed
// and writeback, with burst lock. Wait counters built under SRAM_ARB_PERF_CNT_EN.
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 4,
    parameter int DEPTH     = 1024
)(
    input  logic clk,
    input  logic n_rst,
    sram_bank_arbiter_if.slave bus
);

    localparam int BANK_W = $clog2(NUM_BANKS);

    logic [NUM_REQ-1:0] req_vec, rr_gnt, gnt_vec, owner_mask;
    req_id_t            ptr_q, ptr_d, owner_q, owner_d, gnt_id;
    arb_state_t         state_q, state_d;
    logic               gnt_any, owner_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BANK_W-1:0]  sel_bank;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_read, in_range, cmd_ok;
    logic [NUM_BANKS-1:0] bank_oh;

    logic                 ren_p1, wen_p1, addr_err_p1;
    logic [ADDR_W-1:0]    addr_p1;
    logic [NUM_BANKS-1:0] cs_p1;
    logic [DATA_W-1:0]    wdata_p1;
    logic [BANK_W-1:0]    rd_bank_p1, rd_bank_p2;
    logic                 vld_p2;
    logic [DATA_W-1:0]    rd_mux;

    assign req_vec = {bus.w_req, bus.a_req, bus.h_req};

    rr_arbiter3 u_rr (
        .req (req_vec),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    assign owner_mask = (owner_q == REQ_WB) ? 3'b100 : 3'b001;
    assign owner_lock = (owner_q == REQ_WB) ? bus.w_lock : bus.h_lock;

    // Grants stay low while reset is asserted so held requests see nothing.
    always_comb begin
        gnt_vec = '0;
        if (n_rst) begin
            if (state_q == LOCK) gnt_vec = req_vec & owner_mask;
            else                 gnt_vec = rr_gnt;
        end
    end

    assign gnt_any   = |gnt_vec;
    assign bus.h_gnt = gnt_vec[REQ_HOST];
    assign bus.a_gnt = gnt_vec[REQ_ARRAY];
    assign bus.w_gnt = gnt_vec[REQ_WB];

    always_comb begin
        gnt_id    = REQ_HOST;
        sel_addr  = bus.h_addr;
        sel_bank  = bus.h_bank;
        sel_wdata = bus.h_wdata;
        if (gnt_vec[REQ_ARRAY]) begin
            gnt_id    = REQ_ARRAY;
            sel_addr  = bus.a_addr;
            sel_bank  = bus.a_bank;
            sel_wdata = '0;
        end else if (gnt_vec[REQ_WB]) begin
            gnt_id    = REQ_WB;
            sel_addr  = bus.w_addr;
            sel_bank  = bus.w_bank;
            sel_wdata = bus.w_wdata;
        end
    end

    assign sel_read = (gnt_id == REQ_ARRAY);
    assign in_range = (32'(sel_addr) < 32'(DEPTH));
    assign cmd_ok   = gnt_any & in_range;
    assign bank_oh  = NUM_BANKS'(1) << sel_bank;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB: begin
                if (gnt_any) begin
                    ptr_d = next_req(gnt_id);
                    if ((gnt_id == REQ_HOST && bus.h_lock) ||
                        (gnt_id == REQ_WB && bus.w_lock)) begin
                        state_d = LOCK;
                        owner_d = gnt_id;
                    end
                end
            end
            LOCK: begin
                // Dropping lock ends the burst whether or not the owner is requesting.
                if (!owner_lock) begin
                    state_d = ARB;
                    ptr_d   = next_req(owner_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ARB;
            owner_q <= REQ_HOST;
            ptr_q   <= REQ_HOST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stage p1: registered SRAM command, valid the cycle after the grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ren_p1      <= 1'b0;
            wen_p1      <= 1'b0;
            addr_err_p1 <= 1'b0;
            cs_p1       <= '0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            rd_bank_p1  <= '0;
        end else begin
            ren_p1      <= cmd_ok & sel_read;
            wen_p1      <= cmd_ok & ~sel_read;
            addr_err_p1 <= gnt_any & ~in_range;
            cs_p1       <= cmd_ok ? bank_oh : '0;
            if (cmd_ok) addr_p1 <= sel_addr;
            if (cmd_ok && !sel_read) wdata_p1 <= sel_wdata;
            if (cmd_ok && sel_read) rd_bank_p1 <= sel_bank;
        end
    end

    // Stage p2: SRAM returns data; steer it from the bank captured at p1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p2     <= 1'b0;
            rd_bank_p2 <= '0;
        end else begin
            vld_p2     <= ren_p1;
            rd_bank_p2 <= rd_bank_p1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (int'(rd_bank_p2))
            0:       rd_mux = bus.read_data0;
            1:       rd_mux = bus.read_data1;
            2:       rd_mux = bus.read_data2;
            3:       rd_mux = bus.read_data3;
            default: rd_mux = '0;
        endcase
    end

    assign bus.ren         = ren_p1;
    assign bus.wen         = wen_p1;
    assign bus.addr        = addr_p1;
    assign bus.chip_select = cs_p1;
    assign bus.write_data  = wdata_p1;
    assign bus.addr_err    = addr_err_p1;
    assign bus.a_rvalid    = vld_p2;
    assign bus.a_rdata     = vld_p2 ? rd_mux : '0;

`ifdef SRAM_ARB_PERF_CNT_EN
    logic [NUM_REQ-1:0][15:0] wait_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_vec[i] && !gnt_vec[i] && wait_q[i] != 16'hFFFF)
                    wait_q[i] <= wait_q[i] + 16'd1;
            end
        end
    end

    assign bus.wait_h = wait_q[REQ_HOST];
    assign bus.wait_a = wait_q[REQ_ARRAY];
    assign bus.wait_w = wait_q[REQ_WB];
`else
    assign bus.wait_h = '0;
    assign bus.wait_a = '0;
    assign bus.wait_w = '0;
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of arbitration, command timing and memory.
module tb_sram_bank_arbiter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 64;
    localparam int NUM_BANKS = 4;
    localparam int DEPTH     = 512;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;

    always #5 clk = ~clk;

    sram_bank_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)) bus ();

    sram_bank_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .DEPTH(DEPTH)
    ) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // SRAM buffer: command seen in cycle N+1, read data presented in N+2.
    logic [DATA_W-1:0] mem  [NUM_BANKS][1024];
    logic [DATA_W-1:0] rd_q [NUM_BANKS];

    always @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bus.chip_select[b]) begin
                if (bus.wen) mem[b][bus.addr] <= bus.write_data;
                if (bus.ren) rd_q[b] <= mem[b][bus.addr];
            end
        end
    end

    assign bus.read_data0 = rd_q[0];
    assign bus.read_data1 = rd_q[1];
    assign bus.read_data2 = rd_q[2];
    assign bus.read_data3 = rd_q[3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr;
    int          m_owner;
    int          m_wait [3];
    logic [63:0] shadow [NUM_BANKS][1024];
    bit          e_ren, e_wen, e_err;
    logic [3:0]  e_cs;
    logic [9:0]  e_addr;
    logic [63:0] e_wdata;
    bit          r1_v, r2_v;
    logic [63:0] r1_d, r2_d;
    int          last_g;
    logic [2:0]  obs_gnt;
    logic [3:0]  obs_cs;
    logic [9:0]  obs_addr;
    logic        obs_wen, obs_err;
    logic [15:0] obs_wait_a;
    logic [63:0] rd_log [$];

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        for (int i = 0; i < 3; i++) m_wait[i] = 0;
        e_ren = 0; e_wen = 0; e_err = 0; e_cs = '0; e_addr = '0; e_wdata = '0;
        r1_v = 0; r2_v = 0; r1_d = '0; r2_d = '0;
        last_g = -1;
    endtask

    // One clock cycle: called at posedge+1 with inputs driven, returns at next posedge+1.
    task automatic step();
        int g;
        bit r [3];
        int bank, ad;
        logic [63:0] wd;
        #4;
        r[0] = bus.h_req; r[1] = bus.a_req; r[2] = bus.w_req;
        g = -1;
        if (m_owner >= 0) begin
            if (r[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < 3; k++)
                if (g < 0 && r[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        end

        obs_gnt    = {bus.w_gnt, bus.a_gnt, bus.h_gnt};
        obs_cs     = bus.chip_select;
        obs_addr   = bus.addr;
        obs_wen    = bus.wen;
        obs_err    = bus.addr_err;
        obs_wait_a = bus.wait_a;

        check_eq("grant", 64'(obs_gnt), (g < 0) ? 64'd0 : 64'(1 << g));
        check_eq("ren", 64'(bus.ren), 64'(e_ren));
        check_eq("wen", 64'(bus.wen), 64'(e_wen));
        check_eq("chip_select", 64'(bus.chip_select), 64'(e_cs));
        check_eq("addr_err", 64'(bus.addr_err), 64'(e_err));
        if (e_ren || e_wen) check_eq("addr", 64'(bus.addr), 64'(e_addr));
        if (e_wen) check_eq("write_data", bus.write_data, e_wdata);
        check_eq("a_rvalid", 64'(bus.a_rvalid), 64'(r2_v));
        if (r2_v) check_eq("a_rdata", bus.a_rdata, r2_d);
        if (bus.a_rvalid) rd_log.push_back(bus.a_rdata);
        check_eq("wait_h", 64'(bus.wait_h), 64'(m_wait[0]));
        check_eq("wait_a", 64'(bus.wait_a), 64'(m_wait[1]));
        check_eq("wait_w", 64'(bus.wait_w), 64'(m_wait[2]));

        r2_v = r1_v; r2_d = r1_d;
        r1_v = 0;
        e_ren = 0; e_wen = 0; e_err = 0; e_cs = '0;
        if (g >= 0) begin
            case (g)
                0:       begin ad = int'(bus.h_addr); bank = int'(bus.h_bank); wd = bus.h_wdata; end
                1:       begin ad = int'(bus.a_addr); bank = int'(bus.a_bank); wd = '0; end
                default: begin ad = int'(bus.w_addr); bank = int'(bus.w_bank); wd = bus.w_wdata; end
            endcase
            if (ad >= DEPTH) begin
                e_err = 1;
            end else begin
                e_cs   = 4'(1 << bank);
                e_addr = 10'(ad);
                if (g == 1) begin
                    e_ren = 1; r1_v = 1; r1_d = shadow[bank][ad];
                end else begin
                    e_wen = 1; e_wdata = wd; shadow[bank][ad] = wd;
                end
            end
        end

`ifdef SRAM_ARB_PERF_CNT_EN
        for (int i = 0; i < 3; i++)
            if (r[i] && g != i && m_wait[i] < 65535) m_wait[i]++;
`endif

        if (m_owner >= 0) begin
            if (!((m_owner == 0) ? bus.h_lock : bus.w_lock)) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            if ((g == 0 && bus.h_lock) || (g == 2 && bus.w_lock)) m_owner = g;
        end
        last_g = g;
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int who, input bit rq, input int bank, input int ad,
                           input logic [63:0] wd, input bit lk);
        case (who)
            0: begin bus.h_req = rq; bus.h_bank = 2'(bank); bus.h_addr = 10'(ad);
                     bus.h_wdata = wd; bus.h_lock = lk; end
            1: begin bus.a_req = rq; bus.a_bank = 2'(bank); bus.a_addr = 10'(ad); end
            default: begin bus.w_req = rq; bus.w_bank = 2'(bank); bus.w_addr = 10'(ad);
                     bus.w_wdata = wd; bus.w_lock = lk; end
        endcase
    endtask

    task automatic issue(input int who, input int bank, input int ad,
                         input logic [63:0] wd, input bit lk);
        bit got = 0;
        int t = 0;
        set_req(who, 1'b1, bank, ad, wd, lk);
        while (!got && t < 20) begin
            step();
            got = (last_g == who);
            t++;
        end
        check_eq("issue_granted", 64'(got), 64'd1);
        set_req(who, 1'b0, bank, ad, wd, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        n_rst = 1'b0;
        for (int c = 0; c < hold; c++) begin
            #4;
            check_eq("rst_gnt", 64'({bus.w_gnt, bus.a_gnt, bus.h_gnt}), 64'd0);
            check_eq("rst_ren", 64'(bus.ren), 64'd0);
            check_eq("rst_wen", 64'(bus.wen), 64'd0);
            check_eq("rst_addr", 64'(bus.addr), 64'd0);
            check_eq("rst_cs", 64'(bus.chip_select), 64'd0);
            check_eq("rst_wdata", bus.write_data, 64'd0);
            check_eq("rst_addr_err", 64'(bus.addr_err), 64'd0);
            check_eq("rst_rvalid", 64'(bus.a_rvalid), 64'd0);
            check_eq("rst_rdata", bus.a_rdata, 64'd0);
            check_eq("rst_wait", 64'({bus.wait_h, bus.wait_a, bus.wait_w}), 64'd0);
            @(posedge clk); #1;
        end
        n_rst = 1'b1;
        model_reset();
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(7, 0) == 0) return 10'($urandom_range(1023, 512));
        return 10'($urandom_range(15, 0));
    endfunction

    initial begin
        bit got;
        int t;
        set_req(0, 1'b0, 0, 0, '0, 1'b0);
        set_req(1, 1'b0, 0, 0, '0, 1'b0);
        set_req(2, 1'b0, 0, 0, '0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        do_reset(2);

        // Fill the addresses that random reads may touch.
        for (int b = 0; b < NUM_BANKS; b++)
            for (int a = 0; a < 16; a++)
                issue(0, b, a, {$urandom, $urandom}, 1'b0);

        // Request burst, reset with requests still high, then rotation.
        set_req(0, 1'b1, 0, 20, 64'h1111, 1'b0);
        set_req(1, 1'b1, 0, 1, '0, 1'b0);
        set_req(2, 1'b1, 3, 30, 64'h3333, 1'b0);
        repeat (2) step();
        do_reset(2);
        step();
        check_eq("first_gnt_host", 64'(obs_gnt), 64'b001);
        for (int i = 1; i < 6; i++) begin
            step();
            check_eq("rotate", 64'(obs_gnt), 64'(1 << (i % 3)));
        end
        set_req(0, 1'b0, 0, 0, '0, 1'b0);
        set_req(1, 1'b0, 0, 0, '0, 1'b0);
        set_req(2, 1'b0, 0, 0, '0, 1'b0);

        // Host write bank 2 addr 5: command visible the following cycle.
        issue(0, 2, 5, 64'hC0FFEE, 1'b0);
        step();
        check_eq("cs_bank2", 64'(obs_cs), 64'b0100);
        check_eq("addr_5", 64'(obs_addr), 64'd5);
        check_eq("wen_after_gnt", 64'(obs_wen), 64'd1);

        // Preload bank 1 then four back-to-back reads.
        for (int i = 0; i < 4; i++) issue(0, 1, i, 64'(8'hA0 + i), 1'b0);
        rd_log.delete();
        for (int i = 0; i < 4; i++) issue(1, 1, i, '0, 1'b0);
        repeat (3) step();
        check_eq("burst_count", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check_eq("burst_data", rd_log[i], 64'(8'hA0 + i));

        // Writeback lock burst of six writes with the array waiting.
        for (int i = 0; i < 6; i++) begin
            set_req(2, 1'b1, 3, 8 + i, {$urandom, $urandom}, (i < 5));
            got = 0;
            t = 0;
            while (!got && t < 20) begin
                step();
                if (i > 0) check_eq("lock_a_wait", 64'(obs_gnt[1]), 64'd0);
                got = (last_g == 2);
                t++;
            end
            check_eq("lock_w_gnt", 64'(got), 64'd1);
            if (i == 0) set_req(1, 1'b1, 1, 2, '0, 1'b0);
        end
        set_req(2, 1'b0, 0, 0, '0, 1'b0);
        step();
        check_eq("lock_release", 64'(obs_gnt), 64'b010);
        set_req(1, 1'b0, 0, 0, '0, 1'b0);

        // Out-of-range write and read.
        issue(0, 1, 600, 64'hDEAD, 1'b0);
        step();
        check_eq("oor_addr_err", 64'(obs_err), 64'd1);
        check_eq("oor_no_wen", 64'(obs_wen), 64'd0);
        check_eq("oor_no_cs", 64'(obs_cs), 64'd0);
        rd_log.delete();
        issue(1, 0, 600, '0, 1'b0);
        repeat (3) step();
        check_eq("oor_no_rvalid", 64'(rd_log.size()), 64'd0);

        // Reset asserted in the cycle after a read grant.
        rd_log.delete();
        issue(1, 1, 0, '0, 1'b0);
        do_reset(2);
        repeat (3) step();
        check_eq("rst_drop_rvalid", 64'(rd_log.size()), 64'd0);

        // Array stalled behind two host grants (first one locked).
        set_req(1, 1'b1, 1, 1, '0, 1'b0);
        set_req(0, 1'b1, 0, 21, 64'h55, 1'b1);
        step();
        set_req(0, 1'b1, 0, 22, 64'h66, 1'b0);
        step();
        set_req(0, 1'b0, 0, 0, '0, 1'b0);
        step();
        check_eq("perf_a_gnt", 64'(obs_gnt), 64'b010);
`ifdef SRAM_ARB_PERF_CNT_EN
        check_eq("perf_wait_a", 64'(obs_wait_a), 64'd2);
`else
        check_eq("perf_wait_a", 64'(obs_wait_a), 64'd0);
`endif
        set_req(1, 1'b0, 0, 0, '0, 1'b0);

        // Random traffic.
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.h_req || last_g == 0) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(0, 1'b1, int'($urandom_range(3, 0)), int'(rand_addr()),
                            {$urandom, $urandom}, ($urandom_range(3, 0) == 0));
                else
                    set_req(0, 1'b0, 0, 0, '0, 1'b0);
            end
            if (!bus.a_req || last_g == 1) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(1, 1'b1, int'($urandom_range(3, 0)), int'(rand_addr()), '0, 1'b0);
                else
                    set_req(1, 1'b0, 0, 0, '0, 1'b0);
            end
            if (!bus.w_req || last_g == 2) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(2, 1'b1, int'($urandom_range(3, 0)), int'(rand_addr()),
                            {$urandom, $urandom}, ($urandom_range(3, 0) == 0));
                else
                    set_req(2, 1'b0, 0, 0, '0, 1'b0);
            end
            step();
        end
        set_req(0, 1'b0, 0, 0, '0, 1'b0);
        set_req(1, 1'b0, 0, 0, '0, 1'b0);
        set_req(2, 1'b0, 0, 0, '0, 1'b0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
